// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode/funct constants, the ALU operation enum
// and the packed decoded-instruction bundle passed from decoder to the stage register.
package riscv_pkg;

    localparam int ALU_OP_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_PASS_B,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        rf_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic alu_op_e muldiv_op(input logic [2:0] f3);
        alu_op_e op;
        op = ALU_MUL;
        case (f3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            3'b111:  op = ALU_REMU;
            default: op = ALU_MUL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave = the stage itself, master = the fetch/execute environment driving it.
interface decode_stage_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 5
);
    logic                if_valid;
    logic                if_ready;
    logic [31:0]         if_inst;
    logic [XLEN-1:0]     if_pc;

    logic                id_valid;
    logic                id_ready;
    logic [XLEN-1:0]     id_pc;
    logic [6:0]          id_opcode;
    logic [2:0]          id_funct3;
    logic [4:0]          id_rs1;
    logic [4:0]          id_rs2;
    logic [4:0]          id_rd;
    logic [XLEN-1:0]     id_imm;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic                id_rf_we;
    logic                id_mem_re;
    logic                id_mem_we;
    logic                id_branch;
    logic                id_jump;
    logic                id_illegal;

    modport slave (
        input  if_valid, if_inst, if_pc, id_ready,
        output if_ready, id_valid, id_pc, id_opcode, id_funct3, id_rs1, id_rs2, id_rd,
               id_imm, id_alu_op, id_rf_we, id_mem_re, id_mem_we, id_branch, id_jump,
               id_illegal
    );

    modport master (
        output if_valid, if_inst, if_pc, id_ready,
        input  if_ready, id_valid, id_pc, id_opcode, id_funct3, id_rs1, id_rs2, id_rd,
               id_imm, id_alu_op, id_rf_we, id_mem_re, id_mem_we, id_branch, id_jump,
               id_illegal
    );
endinterface

// File: rtl/inst_decoder.sv
// Combinational RV32I(+M) decoder: raw instruction in, full decoded bundle out.
// Illegal encodings zero all side-effect controls so they can flow harmlessly downstream.
module inst_decoder
    import riscv_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] i_inst,
    output dec_t        o_dec
);
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_ill;
    dec_t        w_dec;

    assign w_opc = i_inst[6:0];
    assign w_f3  = i_inst[14:12];
    assign w_f7  = i_inst[31:25];

    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'b0};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    always_comb begin
        w_dec        = '0;
        w_dec.opcode = w_opc;
        w_dec.funct3 = w_f3;
        w_dec.rs1    = i_inst[19:15];
        w_dec.rs2    = i_inst[24:20];
        w_dec.rd     = i_inst[11:7];
        w_dec.alu_op = ALU_ADD;
        w_ill        = (i_inst[1:0] != 2'b11);

        case (w_opc)
            OPC_LUI: begin
                w_dec.imm    = w_imm_u;
                w_dec.alu_op = ALU_PASS_B;
                w_dec.rf_we  = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.imm   = w_imm_u;
                w_dec.rf_we = 1'b1;
            end
            OPC_JAL: begin
                w_dec.imm   = w_imm_j;
                w_dec.rf_we = 1'b1;
                w_dec.jump  = 1'b1;
            end
            OPC_JALR: begin
                w_dec.imm   = w_imm_i;
                w_dec.rf_we = 1'b1;
                w_dec.jump  = 1'b1;
            end
            OPC_BRANCH: begin
                w_dec.imm    = w_imm_b;
                w_dec.alu_op = ALU_SUB;
                w_dec.branch = 1'b1;
                if (w_f3 == 3'b010 || w_f3 == 3'b011) w_ill = 1'b1;
            end
            OPC_LOAD: begin
                w_dec.imm    = w_imm_i;
                w_dec.rf_we  = 1'b1;
                w_dec.mem_re = 1'b1;
                if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_ill = 1'b1;
            end
            OPC_STORE: begin
                w_dec.imm    = w_imm_s;
                w_dec.mem_we = 1'b1;
                if (w_f3 > 3'b010) w_ill = 1'b1;
            end
            OPC_OP_IMM: begin
                // only shifts treat the upper immediate bits as funct7
                w_dec.imm   = w_imm_i;
                w_dec.rf_we = 1'b1;
                if (w_f3 == F3_SLL) begin
                    w_dec.alu_op = ALU_SLL;
                    if (w_f7 != F7_BASE) w_ill = 1'b1;
                end else if (w_f3 == F3_SR) begin
                    w_dec.alu_op = base_alu_op(w_f3, w_f7[5]);
                    if (w_f7 != F7_BASE && w_f7 != F7_ALT) w_ill = 1'b1;
                end else begin
                    w_dec.alu_op = base_alu_op(w_f3, 1'b0);
                end
            end
            OPC_OP: begin
                w_dec.rf_we = 1'b1;
                case (w_f7)
                    F7_BASE: w_dec.alu_op = base_alu_op(w_f3, 1'b0);
                    F7_ALT: begin
                        if (w_f3 == F3_ADD || w_f3 == F3_SR) begin
                            w_dec.alu_op = base_alu_op(w_f3, 1'b1);
                        end else begin
                            w_ill = 1'b1;
                        end
                    end
                    F7_MULDIV: begin
                        if (ENABLE_M) begin
                            w_dec.alu_op = muldiv_op(w_f3);
                        end else begin
                            w_ill = 1'b1;
                        end
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase

        if (w_ill) begin
            w_dec.rf_we  = 1'b0;
            w_dec.mem_re = 1'b0;
            w_dec.mem_we = 1'b0;
            w_dec.branch = 1'b0;
            w_dec.jump   = 1'b0;
        end
        if (w_dec.rd == 5'd0) w_dec.rf_we = 1'b0;
        w_dec.illegal = w_ill;
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: one registered output slot plus a one-entry skid buffer,
// 1-cycle latency; if_ready is the registered !skid_valid, so fetch never sees a comb path.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int ALU_OP_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_stage_if.slave bus
);
    import riscv_pkg::dec_t;

    logic            r_skid_vld;
    logic [31:0]     r_skid_inst;
    logic [XLEN-1:0] r_skid_pc;
    logic            r_id_vld;
    dec_t            r_dec;
    logic [XLEN-1:0] r_pc;

    logic            w_in_xfer;
    logic            w_out_load;
    logic [31:0]     w_src_inst;
    logic [XLEN-1:0] w_src_pc;
    dec_t            w_dec;

    assign w_in_xfer  = bus.if_valid && !r_skid_vld;
    assign w_out_load = !r_id_vld || bus.id_ready;

    // the skid entry is older than anything on the input, so it always wins the mux
    assign w_src_inst = r_skid_vld ? r_skid_inst : bus.if_inst;
    assign w_src_pc   = r_skid_vld ? r_skid_pc   : bus.if_pc;

    inst_decoder #(
        .ENABLE_M (ENABLE_M)
    ) u_inst_decoder (
        .i_inst (w_src_inst),
        .o_dec  (w_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_vld    <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_dec       <= '0;
            r_pc        <= '0;
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
        end else if (flush) begin
            r_id_vld   <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_out_load) begin
            // a valid skid entry blocks the input, so at most one source exists here
            r_skid_vld <= 1'b0;
            if (r_skid_vld || w_in_xfer) begin
                r_id_vld <= 1'b1;
                r_dec    <= w_dec;
                r_pc     <= w_src_pc;
            end else begin
                r_id_vld <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid_vld  <= 1'b1;
            r_skid_inst <= bus.if_inst;
            r_skid_pc   <= bus.if_pc;
        end
    end

    assign bus.if_ready   = !r_skid_vld;
    assign bus.id_valid   = r_id_vld;
    assign bus.id_pc      = r_pc;
    assign bus.id_opcode  = r_dec.opcode;
    assign bus.id_funct3  = r_dec.funct3;
    assign bus.id_rs1     = r_dec.rs1;
    assign bus.id_rs2     = r_dec.rs2;
    assign bus.id_rd      = r_dec.rd;
    assign bus.id_imm     = XLEN'(r_dec.imm);
    assign bus.id_alu_op  = ALU_OP_W'(r_dec.alu_op);
    assign bus.id_rf_we   = r_dec.rf_we;
    assign bus.id_mem_re  = r_dec.mem_re;
    assign bus.id_mem_we  = r_dec.mem_we;
    assign bus.id_branch  = r_dec.branch;
    assign bus.id_jump    = r_dec.jump;
    assign bus.id_illegal = r_dec.illegal;

endmodule
